// File: rtl/irq_priority_if.sv
// rtl/irq_priority_if.sv - CPU acknowledge handshake between the priority controller and the CPU.
interface irq_priority_if;
    logic       INTA_N;
    logic       INT;
    logic [7:0] VECTOR;
    logic       VECTOR_VALID;

    modport slave  (input INTA_N, output INT, output VECTOR, output VECTOR_VALID);
    modport master (output INTA_N, input INT, input VECTOR, input VECTOR_VALID);
endinterface

// File: rtl/irq_priority.sv
// rtl/irq_priority.sv - 8-level interrupt priority controller with two-pulse INTA vector delivery.
// Define IRQ_ROTATE_EN to enable lowest-priority rotation; otherwise LP stays at 7.
module irq_priority (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [7:0]   IR,
    input  logic [7:0]   ICW1,
    input  logic [7:0]   ICW2,
    input  logic [7:0]   ICW4,
    input  logic [7:0]   OCW1,
    input  logic [7:0]   OCW2,
    input  logic         OCW2_WR,
    input  logic [7:0]   OCW3,
    output logic [7:0]   STATUS,
    irq_priority_if.slave cpu
);
    typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

    state_t     state_q;
    logic [7:0] ir_q, irr_q, isr_q, irr_d, isr_d, status_q, status_d, vector_q;
    logic [2:0] lp_q, lp_d, w_q;
    logic       inta_q, spur_q, int_q, int_d, vv_q;
`ifdef IRQ_ROTATE_EN
    logic       rot_q, rot_d;
`endif

    logic [3:0] pres, ires;
    logic [7:0] pend, ack_set, aeoi_clear, eoi_clear;
    logic       inta_fall, inta_rise, int_cond, aeoi_fire;
    logic       unused_cfg;

    // Returns {found, level}; lowest priority scanned first so the highest one overwrites.
    function automatic logic [3:0] resolve(input logic [7:0] bits, input logic [2:0] lp);
        logic [3:0] r;
        logic [2:0] lvl;
        r = 4'b0;
        for (int i = 8; i >= 1; i--) begin
            lvl = lp + i[2:0];
            if (bits[lvl]) r = {1'b1, lvl};
        end
        return r;
    endfunction

    function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] lp);
        return lvl - lp - 3'd1;
    endfunction

    assign unused_cfg = ^{ICW1[7:4], ICW1[2:0], ICW2[2:0], ICW4[7:2], ICW4[0], OCW2[4:3], OCW3[7:2]};

    assign pend      = irr_q & ~OCW1;
    assign pres      = resolve(pend, lp_q);
    assign ires      = resolve(isr_q, lp_q);
    assign int_cond  = pres[3] && (!ires[3] || (rank(pres[2:0], lp_q) < rank(ires[2:0], lp_q)));
    assign inta_fall = inta_q & ~cpu.INTA_N;
    assign inta_rise = ~inta_q & cpu.INTA_N;
    assign ack_set   = (state_q == IDLE && inta_fall && pres[3]) ? (8'b1 << pres[2:0]) : 8'b0;
    assign aeoi_fire = (state_q == ACK2) && inta_rise && ICW4[1] && !spur_q;
    assign aeoi_clear = aeoi_fire ? (8'b1 << w_q) : 8'b0;

    always_comb begin
        eoi_clear = 8'b0;
        lp_d      = lp_q;
`ifdef IRQ_ROTATE_EN
        rot_d     = rot_q;
`endif
        if (OCW2_WR) begin
            case (OCW2[7:5])
`ifdef IRQ_ROTATE_EN
                3'b001: if (ires[3]) eoi_clear = 8'b1 << ires[2:0];
                3'b011: eoi_clear = 8'b1 << OCW2[2:0];
                3'b101: if (ires[3]) begin
                    eoi_clear = 8'b1 << ires[2:0];
                    lp_d      = ires[2:0];
                end
                3'b111: begin
                    eoi_clear = 8'b1 << OCW2[2:0];
                    lp_d      = OCW2[2:0];
                end
                3'b110: lp_d  = OCW2[2:0];
                3'b100: rot_d = 1'b1;
                3'b000: rot_d = 1'b0;
`else
                3'b001, 3'b101: if (ires[3]) eoi_clear = 8'b1 << ires[2:0];
                3'b011, 3'b111: eoi_clear = 8'b1 << OCW2[2:0];
`endif
                default: ;
            endcase
        end
`ifdef IRQ_ROTATE_EN
        if (aeoi_fire && rot_q) lp_d = w_q;
`endif
    end

    // Level mode follows the pin; the ack clear wins for the cycle it is taken.
    assign irr_d    = (ICW1[3] ? IR : (irr_q | (IR & ~ir_q))) & ~ack_set;
    assign isr_d    = (isr_q & ~eoi_clear & ~aeoi_clear) | ack_set;
    assign int_d    = int_cond && !(state_q == IDLE && inta_fall);
    assign status_d = (OCW3[1:0] == 2'b10) ? irr_q : (OCW3[1:0] == 2'b11) ? isr_q : 8'h00;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            ir_q     <= 8'h00;
            irr_q    <= 8'h00;
            isr_q    <= 8'h00;
            lp_q     <= 3'd7;
            inta_q   <= 1'b1;
            w_q      <= 3'd7;
            spur_q   <= 1'b0;
            int_q    <= 1'b0;
            vector_q <= 8'h00;
            vv_q     <= 1'b0;
            status_q <= 8'h00;
`ifdef IRQ_ROTATE_EN
            rot_q    <= 1'b0;
`endif
        end else begin
            ir_q     <= IR;
            irr_q    <= irr_d;
            isr_q    <= isr_d;
            lp_q     <= lp_d;
            inta_q   <= cpu.INTA_N;
            int_q    <= int_d;
            status_q <= status_d;
`ifdef IRQ_ROTATE_EN
            rot_q    <= rot_d;
`endif
            case (state_q)
                IDLE: if (inta_fall) begin
                    w_q     <= pres[3] ? pres[2:0] : 3'd7;
                    spur_q  <= !pres[3];
                    state_q <= ACK1;
                end
                ACK1: if (inta_fall) begin
                    vector_q <= {ICW2[7:3], w_q};
                    vv_q     <= 1'b1;
                    state_q  <= ACK2;
                end
                ACK2: if (inta_rise) begin
                    vector_q <= 8'h00;
                    vv_q     <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu.INT          = int_q;
    assign cpu.VECTOR       = vector_q;
    assign cpu.VECTOR_VALID = vv_q;
    assign STATUS           = status_q;
endmodule
